// File: rtl/uart_prog_loader.sv
// Serial boot loader: receives an 8N1 framed program image (sync, length, data, checksum)
// and writes it into the processor memory while holding the CPU stalled.
module uart_prog_loader #(
  parameter int unsigned CLKS_PER_BIT = 434,
  parameter int unsigned TIMEOUT_CYC  = 5000000,
  parameter logic [7:0]  SYNC_BYTE    = 8'hA5
) (
  input  logic       CLOCK_50,
  input  logic       RESET_N,
  input  logic       UART_RXD,
  output logic       mem_we,
  output logic [7:0] mem_addr,
  output logic [7:0] mem_wdata,
  output logic       cpu_hold,
  output logic       load_done,
  output logic       load_err,
  output logic       busy
);

  localparam int unsigned CW = $clog2(CLKS_PER_BIT);
  localparam int unsigned TW = $clog2(TIMEOUT_CYC);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
  typedef enum logic [2:0] {F_SYNC, F_LEN, F_DATA, F_SUM, F_DONE} f_state_t;

  rx_state_t     r_rx_state;
  logic          r_rx_meta;
  logic          r_rx_sync;
  logic [CW-1:0] r_clk_cnt;
  logic [2:0]    r_bit_cnt;
  logic [7:0]    r_shift;

  f_state_t      r_f_state;
  logic [7:0]    r_addr;
  logic [7:0]    r_sum;
  logic [8:0]    r_remain;
  logic [TW-1:0] r_to_cnt;
  logic          r_mem_we;
  logic [7:0]    r_mem_addr;
  logic [7:0]    r_mem_wdata;
  logic          r_cpu_hold;
  logic          r_load_done;
  logic          r_load_err;

  logic w_stop_tick;
  logic w_byte_valid;
  logic w_frame_err;
  logic w_in_frame;
  logic w_timeout;
  logic w_abort;

  // Byte strobes are combinational in the stop-sample cycle so the write lands one cycle later.
  assign w_stop_tick  = (r_rx_state == RX_STOP) && (r_clk_cnt == BIT_LAST);
  assign w_byte_valid = w_stop_tick && r_rx_sync;
  assign w_frame_err  = w_stop_tick && !r_rx_sync;
  assign w_in_frame   = (r_f_state == F_LEN) || (r_f_state == F_DATA) || (r_f_state == F_SUM);
  assign w_timeout    = w_in_frame && (r_to_cnt == TO_LAST);
  assign w_abort      = w_in_frame && !w_byte_valid && (w_frame_err || w_timeout);

  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      r_rx_meta  <= 1'b1;
      r_rx_sync  <= 1'b1;
      r_rx_state <= RX_IDLE;
      r_clk_cnt  <= '0;
      r_bit_cnt  <= '0;
      r_shift    <= '0;
    end else begin
      r_rx_meta <= UART_RXD;
      r_rx_sync <= r_rx_meta;
      case (r_rx_state)
        RX_IDLE: begin
          if (!r_rx_sync) begin
            r_rx_state <= RX_START;
            r_clk_cnt  <= '0;
            r_bit_cnt  <= '0;
          end
        end
        RX_START: begin
          if (r_clk_cnt == HALF_LAST) begin
            r_clk_cnt  <= '0;
            r_rx_state <= r_rx_sync ? RX_IDLE : RX_DATA;
          end else begin
            r_clk_cnt <= r_clk_cnt + 1'b1;
          end
        end
        RX_DATA: begin
          if (r_clk_cnt == BIT_LAST) begin
            r_clk_cnt <= '0;
            r_shift   <= {r_rx_sync, r_shift[7:1]};
            r_bit_cnt <= r_bit_cnt + 1'b1;
            if (r_bit_cnt == 3'd7) r_rx_state <= RX_STOP;
          end else begin
            r_clk_cnt <= r_clk_cnt + 1'b1;
          end
        end
        RX_STOP: begin
          if (r_clk_cnt == BIT_LAST) begin
            r_clk_cnt  <= '0;
            r_rx_state <= RX_IDLE;
          end else begin
            r_clk_cnt <= r_clk_cnt + 1'b1;
          end
        end
        default: r_rx_state <= RX_IDLE;
      endcase
    end
  end

  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      r_f_state   <= F_SYNC;
      r_addr      <= '0;
      r_sum       <= '0;
      r_remain    <= '0;
      r_to_cnt    <= '0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_cpu_hold  <= 1'b0;
      r_load_done <= 1'b0;
      r_load_err  <= 1'b0;
    end else begin
      r_mem_we    <= 1'b0;
      r_load_done <= 1'b0;
      if (w_in_frame) r_to_cnt <= w_byte_valid ? '0 : r_to_cnt + 1'b1;
      else            r_to_cnt <= '0;

      if (w_abort) begin
        r_load_err <= 1'b1;
        r_cpu_hold <= 1'b0;
        r_f_state  <= F_SYNC;
      end else begin
        case (r_f_state)
          F_SYNC: begin
            if (w_byte_valid && (r_shift == SYNC_BYTE)) begin
              r_f_state  <= F_LEN;
              r_cpu_hold <= 1'b1;
              r_load_err <= 1'b0;
              r_addr     <= '0;
              r_sum      <= '0;
            end
          end
          F_LEN: begin
            if (w_byte_valid) begin
              r_remain  <= (r_shift == 8'h00) ? 9'd256 : {1'b0, r_shift};
              r_f_state <= F_DATA;
            end
          end
          F_DATA: begin
            if (w_byte_valid) begin
              r_mem_we    <= 1'b1;
              r_mem_addr  <= r_addr;
              r_mem_wdata <= r_shift;
              r_addr      <= r_addr + 1'b1;
              r_sum       <= r_sum + r_shift;
              r_remain    <= r_remain - 1'b1;
              if (r_remain == 9'd1) r_f_state <= F_SUM;
            end
          end
          F_SUM: begin
            if (w_byte_valid) begin
              if (r_shift == r_sum) r_load_done <= 1'b1;
              else                  r_load_err  <= 1'b1;
              r_f_state <= F_DONE;
            end
          end
          F_DONE: begin
            r_cpu_hold <= 1'b0;
            r_f_state  <= F_SYNC;
          end
          default: r_f_state <= F_SYNC;
        endcase
      end
    end
  end

  assign mem_we    = r_mem_we;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign cpu_hold  = r_cpu_hold;
  assign load_done = r_load_done;
  assign load_err  = r_load_err;
  assign busy      = (r_f_state != F_SYNC);

endmodule

// File: tb/tb_uart_prog_loader.sv
// Bench for uart_prog_loader: byte-level frame model schedules expected outputs per cycle,
// one compare process checks every cycle, plus literal checks on key frames.
module tb_uart_prog_loader;

  localparam int CPB  = 8;
  localparam int HALF = CPB / 2;
  localparam int TO   = 100;
  // falling start edge -> frame FSM reacts: 2 sync flops, half bit, 8 data + stop bit
  localparam int LAT  = 2 + HALF + 9 * CPB;
  localparam int MAXC = 60000;

  logic       CLOCK_50 = 1'b0;
  logic       RESET_N  = 1'b0;
  logic       UART_RXD = 1'b1;
  logic       mem_we;
  logic [7:0] mem_addr;
  logic [7:0] mem_wdata;
  logic       cpu_hold;
  logic       load_done;
  logic       load_err;
  logic       busy;

  uart_prog_loader #(.CLKS_PER_BIT(CPB), .TIMEOUT_CYC(TO), .SYNC_BYTE(8'hA5)) dut (
    .CLOCK_50(CLOCK_50), .RESET_N(RESET_N), .UART_RXD(UART_RXD),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .cpu_hold(cpu_hold), .load_done(load_done), .load_err(load_err), .busy(busy)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  int cyc = 0;
  always @(posedge CLOCK_50) cyc = cyc + 1;

  int n_vec = 0;
  int n_fail = 0;

  // expected-output timeline, indexed by posedge number
  bit         e_we   [MAXC];
  logic [7:0] e_a    [MAXC];
  logic [7:0] e_d    [MAXC];
  bit         e_done [MAXC];
  int         c_hold [MAXC];
  int         c_err  [MAXC];

  // frame model: 0 sync, 1 length, 2 data, 3 checksum
  int         ph = 0;
  int         m_n = 0;
  logic [7:0] m_addr = 0;
  logic [7:0] m_sum = 0;
  int         dl = -1;

  logic       cur_hold = 0;
  logic       cur_err = 0;
  logic [7:0] last_a = 0;
  logic [7:0] last_d = 0;

  logic [15:0] wr_log[$];
  int          wr_cyc[$];
  int          done_cnt = 0;
  int          err_rise = -1;
  logic        prev_err = 0;
  int          last_t0 = 0;

  task automatic check(input string name, input int act, input int req);
    n_vec++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d required %0d", name, act, req);
    end
  endtask

  task automatic model_byte(input logic [7:0] b, input bit bad, input int p);
    if (p + TO + 2 >= MAXC) begin
      $display("FAIL cycle_budget: got %0d required below %0d", p + TO + 2, MAXC);
      $fatal(1);
    end
    if (dl >= 0 && dl < p) begin ph = 0; dl = -1; end
    if (dl >= 0) begin c_hold[dl] = -1; c_err[dl] = -1; dl = -1; end
    if (bad) begin
      if (ph != 0) begin c_hold[p] = 0; c_err[p] = 1; ph = 0; end
      return;
    end
    case (ph)
      0: if (b == 8'hA5) begin c_hold[p] = 1; c_err[p] = 0; ph = 1; m_addr = 0; m_sum = 0; end
      1: begin m_n = (b == 8'h00) ? 256 : int'(b); ph = 2; end
      2: begin
        e_we[p] = 1; e_a[p] = m_addr; e_d[p] = b;
        m_addr = m_addr + 8'd1; m_sum = m_sum + b; m_n--;
        if (m_n == 0) ph = 3;
      end
      default: begin
        if (b == m_sum) e_done[p] = 1; else c_err[p] = 1;
        c_hold[p + 1] = 0; ph = 0;
      end
    endcase
    if (ph != 0) begin dl = p + TO; c_hold[dl] = 0; c_err[dl] = 1; end
  endtask

  task automatic model_reset();
    ph = 0; dl = -1; cur_hold = 0; cur_err = 0; last_a = 0; last_d = 0;
    for (int i = cyc; i < MAXC; i++) begin
      e_we[i] = 0; e_done[i] = 0; c_hold[i] = -1; c_err[i] = -1;
    end
  endtask

  // called just after a negedge; returns just after a negedge
  task automatic send_byte(input logic [7:0] b, input bit bad, input int gap);
    int t0;
    int g;
    t0 = cyc + 1;
    last_t0 = t0;
    model_byte(b, bad, t0 + LAT);
    UART_RXD = 1'b0;
    repeat (CPB) @(negedge CLOCK_50);
    for (int i = 0; i < 8; i++) begin
      UART_RXD = b[i];
      repeat (CPB) @(negedge CLOCK_50);
    end
    UART_RXD = !bad;
    repeat (CPB) @(negedge CLOCK_50);
    UART_RXD = 1'b1;
    g = (bad && gap < 12) ? 12 : gap;
    repeat (g) @(negedge CLOCK_50);
  endtask

  logic [20:0] actv;
  logic [20:0] expv;
  initial begin
    @(negedge CLOCK_50);
    forever begin
      int c;
      c = cyc;
      if (c < MAXC) begin
        if (c_hold[c] >= 0) cur_hold = (c_hold[c] == 1);
        if (c_err[c] >= 0)  cur_err  = (c_err[c] == 1);
        if (e_we[c]) begin last_a = e_a[c]; last_d = e_d[c]; end
        expv = {e_we[c], last_a, last_d, e_done[c], cur_err, cur_hold, cur_hold};
        actv = {mem_we, mem_addr, mem_wdata, load_done, load_err, cpu_hold, busy};
        n_vec++;
        if (actv !== expv) begin
          n_fail++;
          $display("FAIL cycle %0d {we,addr,wdata,done,err,hold,busy}: got %h required %h", c, actv, expv);
        end
        if (mem_we === 1'b1) begin wr_log.push_back({mem_addr, mem_wdata}); wr_cyc.push_back(c); end
        if (load_done === 1'b1) done_cnt++;
        if (load_err === 1'b1 && prev_err === 1'b0) err_rise = c;
        prev_err = load_err;
      end
      @(negedge CLOCK_50);
    end
  end

  initial begin
    #(MAXC * 10);
    $display("FAIL watchdog: got time %0t required finish before it", $time);
    $fatal(1);
  end

  initial begin
    int w0, d0, t_data, p_len, nbad, exp_done, rnd_len;
    logic [7:0] sum, b;
    for (int i = 0; i < MAXC; i++) begin c_hold[i] = -1; c_err[i] = -1; end

    repeat (4) @(negedge CLOCK_50);
    RESET_N = 1'b1;
    repeat (5) @(negedge CLOCK_50);
    check("reset_state", int'({mem_we, mem_addr, mem_wdata, load_done, load_err, cpu_hold, busy}), 0);

    // good frame
    w0 = wr_log.size(); d0 = done_cnt;
    send_byte(8'hA5, 0, 0);
    check("hold_after_sync", int'(cpu_hold), 1);
    send_byte(8'h03, 0, 2);
    send_byte(8'h11, 0, 0);
    t_data = last_t0;
    send_byte(8'h22, 0, 3);
    send_byte(8'h33, 0, 1);
    send_byte(8'h66, 0, 0);
    repeat (4) @(negedge CLOCK_50);
    check("good_nwrites", wr_log.size() - w0, 3);
    if (wr_log.size() >= w0 + 3) begin
      check("good_wr0", int'(wr_log[w0]),     16'h0011);
      check("good_wr1", int'(wr_log[w0 + 1]), 16'h0122);
      check("good_wr2", int'(wr_log[w0 + 2]), 16'h0233);
      check("write_latency", wr_cyc[w0] - t_data, 78);
    end
    check("good_done", done_cnt - d0, 1);
    check("good_err", int'(load_err), 0);
    check("good_hold_released", int'(cpu_hold), 0);

    // bad checksum, then a good frame clears the error at its sync byte
    w0 = wr_log.size(); d0 = done_cnt;
    send_byte(8'hA5, 0, 0); send_byte(8'h02, 0, 0);
    send_byte(8'h10, 0, 0); send_byte(8'h20, 0, 0); send_byte(8'h31, 0, 4);
    check("badsum_err", int'(load_err), 1);
    check("badsum_nwrites", wr_log.size() - w0, 2);
    check("badsum_done", done_cnt - d0, 0);
    send_byte(8'hA5, 0, 0);
    check("sync_clears_err", int'(load_err), 0);
    send_byte(8'h01, 0, 0); send_byte(8'h07, 0, 0); send_byte(8'h07, 0, 4);

    // length 0 means 256 bytes
    w0 = wr_log.size(); d0 = done_cnt;
    send_byte(8'hA5, 0, 0); send_byte(8'h00, 0, 0);
    for (int i = 0; i < 256; i++) send_byte(8'(i), 0, 0);
    send_byte(8'h80, 0, 4);
    check("len256_nwrites", wr_log.size() - w0, 256);
    nbad = 0;
    if (wr_log.size() >= w0 + 256)
      for (int i = 0; i < 256; i++) if (wr_log[w0 + i] != {8'(i), 8'(i)}) nbad++;
    check("len256_order", nbad, 0);
    check("len256_done", done_cnt - d0, 1);

    // glitch then a non-sync byte
    w0 = wr_log.size();
    UART_RXD = 1'b0;
    repeat (2) @(negedge CLOCK_50);
    UART_RXD = 1'b1;
    repeat (20) @(negedge CLOCK_50);
    send_byte(8'h5A, 0, 10);
    check("noise_busy", int'(busy), 0);
    check("noise_hold", int'(cpu_hold), 0);
    check("noise_nwrites", wr_log.size() - w0, 0);

    // framing error on second data byte
    w0 = wr_log.size();
    send_byte(8'hA5, 0, 0); send_byte(8'h03, 0, 0);
    send_byte(8'h44, 0, 0); send_byte(8'h55, 1, 12);
    check("ferr_err", int'(load_err), 1);
    check("ferr_hold", int'(cpu_hold), 0);
    check("ferr_busy", int'(busy), 0);
    check("ferr_nwrites", wr_log.size() - w0, 1);

    // inter-byte timeout after the length byte
    w0 = wr_log.size();
    send_byte(8'hA5, 0, 0);
    send_byte(8'h04, 0, 0);
    p_len = last_t0 + LAT;
    repeat (130) @(negedge CLOCK_50);
    check("timeout_cycle", err_rise - p_len, 100);
    check("timeout_err", int'(load_err), 1);
    check("timeout_busy", int'(busy), 0);
    check("timeout_nwrites", wr_log.size() - w0, 0);

    // randomized frames
    d0 = done_cnt; exp_done = 0;
    for (int f = 0; f < 6; f++) begin
      rnd_len = $urandom_range(6, 1);
      sum = 0;
      send_byte(8'hA5, 0, $urandom_range(8, 0));
      send_byte(8'(rnd_len), 0, $urandom_range(8, 0));
      for (int i = 0; i < rnd_len; i++) begin
        b = 8'($urandom);
        sum = sum + b;
        send_byte(b, 0, $urandom_range(8, 0));
      end
      if ($urandom_range(2, 0) == 0) send_byte(sum ^ 8'h01, 0, 6);
      else begin send_byte(sum, 0, 6); exp_done++; end
    end
    check("random_done", done_cnt - d0, exp_done);

    // asynchronous reset in the middle of a data byte
    send_byte(8'hA5, 0, 0); send_byte(8'h05, 0, 0);
    send_byte(8'h01, 0, 0); send_byte(8'h02, 0, 0);
    UART_RXD = 1'b0;
    repeat (3 * CPB) @(negedge CLOCK_50);
    @(posedge CLOCK_50);
    #3;
    RESET_N = 1'b0;
    model_reset();
    UART_RXD = 1'b1;
    w0 = wr_log.size();
    #1;
    check("async_reset_outputs", int'({mem_we, mem_addr, mem_wdata, load_done, load_err, cpu_hold, busy}), 0);
    repeat (5) @(negedge CLOCK_50);
    RESET_N = 1'b1;
    repeat (150) @(negedge CLOCK_50);
    check("post_reset_nwrites", wr_log.size() - w0, 0);

    // recovery after reset
    d0 = done_cnt;
    send_byte(8'hA5, 0, 0); send_byte(8'h01, 0, 0);
    send_byte(8'h5A, 0, 0); send_byte(8'h5A, 0, 4);
    check("recover_done", done_cnt - d0, 1);
    check("recover_last_write", int'({mem_addr, mem_wdata}), 16'h005A);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_prog_loader.md
Name: uart_prog_loader

Overview:
- Serial boot loader upstream of the SimProc processor's 256x8 program/data memory.
- Receives a framed program image over 8N1 UART from a host PC and writes it byte-by-byte into memory at addresses 0..N-1.
- Holds the processor stalled while loading, then reports success or error.
- The processor's memory gains a second write port driven by mem_we, mem_addr and mem_wdata, muxed in while cpu_hold is high.

Parameters:
- CLKS_PER_BIT, 434, CLOCK_50 cycles per UART bit (50 MHz / 115200); minimum 8.
- TIMEOUT_CYC, 5000000, idle cycles allowed between bytes inside a frame before abort (100 ms).
- SYNC_BYTE, 8'hA5, frame start marker.

Ports:
- CLOCK_50  in  1  system clock.
- RESET_N  in  1  asynchronous, active-low reset.
- UART_RXD  in  1  serial input, idle high, asynchronous to CLOCK_50.
- mem_we  out  1  memory write strobe, one cycle per data byte.
- mem_addr  out  8  write address.
- mem_wdata  out  8  write data.
- cpu_hold  out  1  high while a frame is in progress; the processor FSM/PC must not advance.
- load_done  out  1  one-cycle pulse on a good checksum.
- load_err  out  1  sticky error flag; cleared when the next SYNC_BYTE is accepted.
- busy  out  1  high when the frame FSM is not in F_SYNC.

Behaviour:
- Reset is asynchronous and active-low. On assertion:
  - all outputs go to 0;
  - RX state is RX_IDLE and frame state is F_SYNC;
  - counters and checksum are cleared;
  - the synchroniser flops are set to 1 (idle line).
- Reset mid-frame abandons the frame. No write is issued in the reset cycle or after it.
- UART_RXD passes through a 2-flop synchroniser. All sampling uses the second flop.
- RX FSM:
  - RX_IDLE: on sampled low, go to RX_START and clear the bit counter.
  - RX_START: wait CLKS_PER_BIT/2 cycles (integer divide), then resample. If high, it is a false start: return to RX_IDLE. If low, go to RX_DATA.
  - RX_DATA: every CLKS_PER_BIT cycles, sample one bit, LSB first, into the shift register. After the 8th bit go to RX_STOP.
  - RX_STOP: after CLKS_PER_BIT cycles, sample. If 1, issue a one-cycle internal byte_valid with the byte. If 0, issue a one-cycle internal frame_err. Either way return to RX_IDLE.
  - The RX FSM ignores frame state and never stalls.
- Frame FSM (advances only on byte_valid, frame_err or timeout):
  - F_SYNC: a byte equal to SYNC_BYTE goes to F_LEN; it sets cpu_hold, clears load_err, and zeroes the address counter and checksum. Any other byte is discarded and the FSM stays in F_SYNC.
  - F_LEN: the byte is latched as count N; 0 means 256. Go to F_DATA.
  - F_DATA: each byte drives mem_we=1 for exactly one cycle, with mem_addr equal to the address counter and mem_wdata equal to the byte. The write occurs the cycle after byte_valid. The checksum accumulates the byte mod 256. The address counter increments and wraps 8'hFF to 8'h00. After the Nth byte go to F_SUM.
  - F_SUM: if the byte equals the checksum, pulse load_done. Otherwise set load_err. Either way go to F_DONE.
  - F_DONE: for one cycle, deassert cpu_hold, then go to F_SYNC.
- Data handling rules:
  - A SYNC_BYTE value received in F_LEN, F_DATA or F_SUM is treated as ordinary data, not a resync.
  - mem_addr and mem_wdata hold their last values when mem_we=0.
- Errors:
  - frame_err in any state other than F_SYNC sets load_err, drops cpu_hold next cycle and returns to F_SYNC. Bytes already written stay in memory.
  - frame_err in F_SYNC is ignored.
  - Timeout: in F_LEN, F_DATA or F_SUM, a counter counts cycles since the last byte_valid. At TIMEOUT_CYC it aborts exactly as frame_err does. The counter is reset by byte_valid and is idle in F_SYNC.
  - Simultaneous byte_valid and timeout in the same cycle: byte_valid wins and clears the counter.
- Latency: from the stop-bit sample to the mem_we pulse is 1 cycle; from the checksum byte's stop-bit sample to load_done is 1 cycle.
- load_done and load_err are mutually exclusive per frame.

Test Plan:
- Good frame: A5, 03, 11, 22, 33, 66 at CLKS_PER_BIT=8 -> mem_we pulses 3 times, writing (00,11), (01,22), (02,33). cpu_hold is high from the A5 stop bit until the cycle after load_done. load_err=0.
- Bad checksum: A5, 02, 10, 20, 31 -> 2 writes, no load_done, load_err=1. A following good frame clears load_err at its A5.
- Length 0 (256 bytes of value i, checksum 80) -> 256 writes, addresses 00..FF in order, no write to address 00 after wrap, load_done=1.
- Noise: 2-cycle low glitch on idle line, then byte 5A before A5 -> no byte_valid from the glitch, 5A discarded, FSM stays in F_SYNC, busy=0.
- Framing error: stop bit forced 0 on the second data byte -> load_err=1, cpu_hold drops, FSM returns to F_SYNC, only 1 write occurred.
- Timeout/reset: with TIMEOUT_CYC=100, stop after the length byte -> abort at cycle 100 with load_err=1. Separately, assert RESET_N mid-F_DATA -> all outputs 0 immediately (asynchronous), and no further writes.
